// File: rtl/multi_edge_detect_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_edge_detect_if
// Purpose  : Bundles the control and status signals of multi_edge_detect.
//            The owning device (master) drives the enables, mode and clear
//            strobes. The edge detector (slave) returns levels, pulses,
//            sticky flags and the summary interrupt request.
// Signals  : clken            filter/sample enable
//            i[WIDTH]         raw channel inputs
//            mode[2*WIDTH]    per-channel edge select (00 off, 01 rise,
//                             10 fall, 11 both)
//            ie[WIDTH]        per-channel interrupt enable
//            clr[WIDTH]       write-1-to-clear for pend/ovf
//            lvl[WIDTH]       filtered level
//            o[WIDTH]         one-clock edge pulse
//            pend[WIDTH]      sticky pending flags
//            ovf[WIDTH]       sticky overrun flags
//            irq              OR of enabled pending flags
// Revision : 1.0  initial release
// ============================================================================
interface multi_edge_detect_if #(
  parameter int WIDTH = 8
);
  logic                 clken;
  logic [WIDTH-1:0]     i;
  logic [2*WIDTH-1:0]   mode;
  logic [WIDTH-1:0]     ie;
  logic [WIDTH-1:0]     clr;
  logic [WIDTH-1:0]     lvl;
  logic [WIDTH-1:0]     o;
  logic [WIDTH-1:0]     pend;
  logic [WIDTH-1:0]     ovf;
  logic                 irq;

  modport master (
    output clken, i, mode, ie, clr,
    input  lvl, o, pend, ovf, irq
  );

  modport slave (
    input  clken, i, mode, ie, clr,
    output lvl, o, pend, ovf, irq
  );
endinterface
`default_nettype wire

// File: rtl/multi_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : multi_edge_detect
// Purpose  : Multi-channel edge detector. Each channel passes through a
//            SYNC-stage synchroniser, a FILT-sample stability filter and an
//            edge qualifier selected by mode. Qualified edges produce a
//            one-clock pulse, a sticky pending flag and an overrun flag.
// Ports    : clk   clock
//            rst   asynchronous, active-low reset
//            bus   multi_edge_detect_if slave modport (see interface file)
// Params   : WIDTH channels, SYNC synchroniser depth (0 = none),
//            FILT stability samples (1 = no filtering), INIT reset level
// Revision : 1.0  initial release
// ============================================================================
module multi_edge_detect #(
  parameter int               WIDTH = 8,
  parameter int               SYNC  = 2,
  parameter int               FILT  = 4,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  multi_edge_detect_if.slave   bus
);

  // FILT = 1 needs no counter bits, but a zero-width vector is illegal.
  localparam int                 c_CNT_W   = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(FILT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  logic [WIDTH-1:0]   w_s;
  logic [c_CNT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0]   r_lvl;
  logic [WIDTH-1:0]   r_o;
  logic [WIDTH-1:0]   r_pend;
  logic [WIDTH-1:0]   r_ovf;
  logic [WIDTH-1:0]   w_evt;
  logic [WIDTH-1:0]   w_qual;

  // --------------------------------------------------------------------------
  // Synchroniser: runs every clk, independent of clken.
  // --------------------------------------------------------------------------
  generate
    if (SYNC == 0) begin : g_nosync
      assign w_s = bus.i;
    end else begin : g_sync
      logic [WIDTH-1:0] r_sync [SYNC];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int j = 0; j < SYNC; j++) begin
            r_sync[j] <= INIT;
          end
        end else begin
          r_sync[0] <= bus.i;
          for (int j = 1; j < SYNC; j++) begin
            r_sync[j] <= r_sync[j-1];
          end
        end
      end

      assign w_s = r_sync[SYNC-1];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Level-change event: the synchronised input has differed from the filtered
  // level for FILT consecutive clken samples (this one included). The edge
  // direction is the new level, qualified by the channel's mode bits.
  // --------------------------------------------------------------------------
  always_comb begin
    w_evt  = '0;
    w_qual = '0;
    for (int k = 0; k < WIDTH; k++) begin
      w_evt[k]  = bus.clken && (w_s[k] != r_lvl[k]) && (r_cnt[k] == c_CNT_MAX);
      w_qual[k] = w_evt[k] && (w_s[k] ? bus.mode[2*k] : bus.mode[2*k+1]);
    end
  end

  // --------------------------------------------------------------------------
  // Filter state, pulse and sticky flags.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < WIDTH; k++) begin
        r_cnt[k] <= '0;
      end
      r_lvl  <= INIT;
      r_o    <= '0;
      r_pend <= '0;
      r_ovf  <= '0;
    end else begin
      // w_qual already includes clken, so o drops on every non-clken edge.
      r_o    <= w_qual;
      // A new event beats a simultaneous clear for pend; the overrun from that
      // same event is cleared, since software has just acknowledged it.
      r_pend <= w_qual | (r_pend & ~bus.clr);
      r_ovf  <= (r_ovf | (w_qual & r_pend)) & ~bus.clr;

      if (bus.clken) begin
        for (int k = 0; k < WIDTH; k++) begin
          if (w_s[k] == r_lvl[k]) begin
            r_cnt[k] <= '0;
          end else if (r_cnt[k] == c_CNT_MAX) begin
            r_lvl[k] <= w_s[k];
            r_cnt[k] <= '0;
          end else begin
            r_cnt[k] <= r_cnt[k] + c_CNT_ONE;
          end
        end
      end
    end
  end

  assign bus.lvl  = r_lvl;
  assign bus.o    = r_o;
  assign bus.pend = r_pend;
  assign bus.ovf  = r_ovf;
  assign bus.irq  = |(r_pend & bus.ie);

endmodule
`default_nettype wire

// File: tb/tb_multi_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_edge_detect
// Purpose  : Directed, table-driven bench for multi_edge_detect with default
//            parameters (WIDTH 8, SYNC 2, FILT 4, INIT 0).
// Revision : 1.0  initial release
// ============================================================================
module tb_multi_edge_detect;

  localparam int c_W = 8;

  typedef struct {
    logic [7:0]  i;
    logic [7:0]  ie;
    logic [7:0]  clr;
    logic [7:0]  lvl;
    logic [7:0]  o;
    logic [7:0]  pend;
    logic [7:0]  ovf;
    logic        irq;
  } vec_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  multi_edge_detect_if #(.WIDTH(c_W)) bus ();

  multi_edge_detect #(
    .WIDTH (c_W),
    .SYNC  (2),
    .FILT  (4),
    .INIT  (8'h00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Channel-0-only vector: other channels stay idle (input 0, mode off).
  function automatic vec_t mk(bit i0, bit clr0, bit ie0, bit l, bit o, bit p, bit q);
    vec_t v;
    v.i    = {7'b0, i0};
    v.clr  = {7'b0, clr0};
    v.ie   = {7'b0, ie0};
    v.lvl  = {7'b0, l};
    v.o    = {7'b0, o};
    v.pend = {7'b0, p};
    v.ovf  = 8'h00;
    v.irq  = q;
    return v;
  endfunction

  vec_t tv [33];

  initial begin
    int first_o;
    int pulses;
    n_vec = 0;
    n_err = 0;

    // Channel 0, rising only. Vector n is driven before clk edge n.
    for (int k = 0; k < 5; k++)  tv[k] = mk(1, 0, 1, 0, 0, 0, 0); // edges 1-5: filtering
    tv[5]  = mk(1, 0, 1, 1, 1, 1, 1);                             // edge 6: accept rise
    tv[6]  = mk(1, 0, 1, 1, 0, 1, 1);                             // pulse ends
    tv[7]  = mk(0, 1, 1, 1, 0, 0, 0);                             // clear, input falls
    for (int k = 8; k < 12; k++) tv[k] = mk(0, 0, 1, 1, 0, 0, 0);
    tv[12] = mk(0, 0, 1, 0, 0, 0, 0);                             // edge 13: fall, no pulse
    tv[13] = mk(0, 0, 1, 0, 0, 0, 0);
    for (int k = 14; k < 17; k++) tv[k] = mk(1, 0, 1, 0, 0, 0, 0); // 3-cycle glitch
    for (int k = 17; k < 22; k++) tv[k] = mk(0, 0, 1, 0, 0, 0, 0);
    for (int k = 22; k < 26; k++) tv[k] = mk(1, 0, 1, 0, 0, 0, 0); // 4-cycle pulse
    tv[26] = mk(0, 0, 1, 0, 0, 0, 0);
    tv[27] = mk(0, 0, 1, 1, 1, 1, 1);                             // edge 28: accepted
    for (int k = 28; k < 31; k++) tv[k] = mk(0, 0, 1, 1, 0, 1, 1);
    tv[31] = mk(0, 0, 0, 0, 0, 1, 0);                             // fall; ie off masks irq
    tv[32] = mk(0, 1, 1, 0, 0, 0, 0);                             // clear

    // ---------------- reset ----------------
    rst       = 1'b0;
    bus.clken = 1'b1;
    bus.i     = 8'h00;
    bus.mode  = 16'h0001;
    bus.ie    = 8'hFF;
    bus.clr   = 8'h00;
    step(3);
    chk("reset_state", {bus.lvl, bus.o, bus.pend, bus.ovf, 7'b0, bus.irq}, 40'h0);
    @(negedge clk);
    rst = 1'b1;
    bus.ie = 8'h01;
    step(1);

    // ---------------- table ----------------
    for (int k = 0; k < 33; k++) begin
      bus.i   = tv[k].i;
      bus.ie  = tv[k].ie;
      bus.clr = tv[k].clr;
      step(1);
      if ({bus.lvl, bus.o, bus.pend, bus.ovf, bus.irq} !==
          {tv[k].lvl, tv[k].o, tv[k].pend, tv[k].ovf, tv[k].irq}) begin
        $display("FAIL vec%0d: got lvl=%h o=%h pend=%h ovf=%h irq=%b expected lvl=%h o=%h pend=%h ovf=%h irq=%b",
                 k + 1, bus.lvl, bus.o, bus.pend, bus.ovf, bus.irq,
                 tv[k].lvl, tv[k].o, tv[k].pend, tv[k].ovf, tv[k].irq);
        n_err++;
      end
      n_vec++;
    end
    bus.clr = 8'h00;

    // ---------------- overrun, clear vs. event ----------------
    bus.mode = 16'h0003;
    bus.i    = 8'h01;
    step(6);
    chk("ovf_edge1", {bus.lvl, bus.o, bus.pend, bus.ovf}, {8'h01, 8'h01, 8'h01, 8'h00});
    bus.i = 8'h00;
    step(5);
    chk("ovf_gap", {32'h0, bus.o}, 40'h0);
    step(1);
    chk("ovf_edge2", {bus.lvl, bus.o, bus.pend, bus.ovf}, {8'h00, 8'h01, 8'h01, 8'h01});
    bus.i = 8'h01;
    step(5);
    bus.clr = 8'h01;
    step(1);
    chk("clr_vs_edge", {bus.lvl, bus.o, bus.pend, bus.ovf}, {8'h01, 8'h01, 8'h01, 8'h00});
    bus.clr = 8'h00;

    // ---------------- independent channels 3 (fall) and 5 (rise) ----------------
    bus.clr = 8'hFF;
    step(1);
    bus.clr  = 8'h00;
    bus.mode = 16'h0480;
    bus.ie   = 8'h28;
    bus.i    = 8'h09;
    step(8);
    chk("ch3_rise_ignored", {bus.lvl, bus.o, bus.pend}, {8'h09, 8'h00, 8'h00});
    bus.i = 8'h21;
    step(5);
    chk("ch35_pre", {32'h0, bus.o}, 40'h0);
    step(1);
    chk("ch35_edge", {bus.lvl, bus.o, bus.pend, 7'b0, bus.irq}, {8'h21, 8'h28, 8'h28, 8'h01});
    step(1);
    chk("ch35_pulse_end", {32'h0, bus.o}, 40'h0);

    // ---------------- clken every second clock, channel 1 rising ----------------
    bus.clr = 8'hFF;
    step(1);
    bus.clr  = 8'h00;
    bus.mode = 16'h0004;
    first_o  = 0;
    pulses   = 0;
    for (int c = 1; c <= 20; c++) begin
      bus.clken = c[0];
      if (c == 1) bus.i = 8'h23;
      step(1);
      if (bus.clken == 1'b0) chk($sformatf("o_clken_low_c%0d", c), {63'b0, bus.o[1]}, 64'h0);
      if (bus.o[1] === 1'b1) begin
        pulses++;
        if (first_o == 0) first_o = c;
      end
    end
    bus.clken = 1'b1;
    chk("clken_latency_in_window", {63'b0, (first_o >= 9 && first_o <= 11)}, 64'h1);
    chk("clken_pulse_count", 64'(pulses), 64'h1);
    chk("clken_lvl_pend", {bus.lvl, bus.pend}, {8'h23, 8'h02});

    // ---------------- asynchronous reset mid-filter ----------------
    bus.mode = 16'hFFFF;
    bus.ie   = 8'hFF;
    bus.clr  = 8'hFF;
    step(1);
    bus.clr = 8'h00;
    bus.i   = 8'hDC;
    step(6);
    chk("all_pend", {bus.o, bus.pend, 7'b0, bus.irq}, {8'hFF, 8'hFF, 8'h01});
    bus.i = 8'h23;
    step(3);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset", {bus.lvl, bus.o, bus.pend, bus.ovf, 7'b0, bus.irq}, 40'h0);
    bus.i = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step(1);
      chk($sformatf("post_reset_quiet_c%0d", c), {bus.lvl, bus.o, bus.pend, 7'b0, bus.irq}, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
